// File: rtl/pip_ctrl_mc.sv
// Pipeline controller: RAW/WAW hazard detection with bypass selection, long-op
// register scoreboard, flush FSM and EX-stall watchdog.
module pip_ctrl_mc #(
    parameter int NBACK   = 2,
    parameter int IDX_W   = 5,
    parameter int FWD_EN  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [IDX_W-1:0]       id_rs1_index,
    input  logic [IDX_W-1:0]       id_rs2_index,
    input  logic [IDX_W-1:0]       id_rd_index,
    input  logic                   id_gpr_write,
    input  logic                   id_long_op,
    input  logic                   id_exception,
    input  logic                   id_fence,
    input  logic [NBACK-1:0]       bk_valid,
    input  logic [NBACK*IDX_W-1:0] bk_rd_index,
    input  logic [NBACK-1:0]       bk_gpr_write,
    input  logic [NBACK-1:0]       bk_fwd_ok,
    input  logic [NBACK-1:0]       bk_exception,
    input  logic [NBACK-1:0]       bk_fence,
    input  logic                   ex_ready,
    input  logic                   lo_done,
    input  logic [IDX_W-1:0]       lo_done_index,
    input  logic                   redirect,
    output logic                   if_nop,
    output logic                   if_hold,
    output logic                   id_nop,
    output logic                   id_hold,
    output logic [NBACK-1:0]       bk_nop,
    output logic [NBACK-1:0]       fwd_rs1_sel,
    output logic [NBACK-1:0]       fwd_rs2_sel,
    output logic                   flushing,
    output logic                   wdt_timeout
);

    localparam int NREG = 1 << IDX_W;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [NREG-1:0] sb;

    logic [NBACK-1:0] bk_kill;
    logic [NBACK-1:0] bk_wr;
    logic [NBACK-1:0] bk_nop_c;
    logic             bflush;
    logic             iexc;
    logic             in_flush;
    logic [NBACK:0]   raw1;
    logic [NBACK:0]   raw2;
    logic             waw;
    logic             haz;
    logic             if_nop_c;
    logic             id_nop_c;
    logic             id_hold_c;
    logic             issue;
    logic             sb_set;
    logic             sb_clr;
    logic             wdt_hit;

    // Returns {stall, one-hot bypass select}; the youngest matching stage decides.
    function automatic logic [NBACK:0] raw_check(
        input logic [IDX_W-1:0]       rs,
        input logic                   vld,
        input logic [NBACK-1:0]       wr,
        input logic [NBACK*IDX_W-1:0] rd,
        input logic [NBACK-1:0]       fok,
        input logic                   sb_bit
    );
        logic [NBACK-1:0] sel;
        logic             stall;
        logic             hit;
        sel   = '0;
        stall = 1'b0;
        hit   = 1'b0;
        if (vld && rs != '0) begin
            for (int k = 0; k < NBACK; k++) begin
                if (!hit && wr[k] && rd[k*IDX_W +: IDX_W] == rs) begin
                    hit = 1'b1;
                    if (FWD_EN != 0 && fok[k])
                        sel[k] = 1'b1;
                    else
                        stall = 1'b1;
                end
            end
            if (sb_bit)
                stall = 1'b1;
        end
        return {stall, sel};
    endfunction

    assign bk_kill = bk_valid & (bk_exception | bk_fence);
    assign bk_wr   = bk_valid & bk_gpr_write;
    assign bflush  = |bk_kill;
    assign iexc    = id_valid & id_exception;

    // Each stage is squashed by any killing instruction older than itself.
    always_comb begin
        bk_nop_c = '0;
        for (int k = NBACK - 2; k >= 0; k--)
            bk_nop_c[k] = bk_nop_c[k+1] | bk_kill[k+1];
    end

    assign raw1 = raw_check(id_rs1_index, id_valid, bk_wr, bk_rd_index, bk_fwd_ok, sb[id_rs1_index]);
    assign raw2 = raw_check(id_rs2_index, id_valid, bk_wr, bk_rd_index, bk_fwd_ok, sb[id_rs2_index]);
    assign waw  = id_gpr_write & (id_rd_index != '0) & sb[id_rd_index];
    assign haz  = raw1[NBACK] | raw2[NBACK] | waw;

    assign in_flush  = (state == FLUSH);
    assign if_nop_c  = bflush | iexc | in_flush;
    assign id_nop_c  = bflush | in_flush | haz;
    assign id_hold_c = !id_nop_c & !ex_ready;
    assign issue     = id_valid & !id_nop_c & !id_hold_c & ex_ready;

    assign sb_set = issue & id_long_op & id_gpr_write & (id_rd_index != '0);
    assign sb_clr = lo_done & (lo_done_index != '0);

    // Reset forces bubbles everywhere and silences every other control.
    assign if_nop      = !rst_n | if_nop_c;
    assign id_nop      = !rst_n | id_nop_c;
    assign if_hold     = rst_n & !if_nop_c & (haz | !ex_ready | (id_valid & id_fence));
    assign id_hold     = rst_n & id_hold_c;
    assign bk_nop      = rst_n ? bk_nop_c : '1;
    assign fwd_rs1_sel = {NBACK{rst_n}} & raw1[NBACK-1:0];
    assign fwd_rs2_sel = {NBACK{rst_n}} & raw2[NBACK-1:0];
    assign flushing    = rst_n & in_flush;
    assign wdt_timeout = rst_n & wdt_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            if (sb_clr)
                sb[lo_done_index] <= 1'b0;
            // Later assignment wins when set and clear target the same entry.
            if (sb_set)
                sb[id_rd_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if ((bflush | iexc) && !redirect) state_nxt = FLUSH;
            FLUSH:   if (redirect) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_wdt
            localparam int WDT_W = $clog2(TIMEOUT + 1);
            localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(TIMEOUT);
            localparam logic [WDT_W-1:0] WDT_PRE = WDT_W'(TIMEOUT - 1);

            logic [WDT_W-1:0] wdt_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n || ex_ready)
                    wdt_cnt <= '0;
                else if (wdt_cnt != WDT_MAX)
                    wdt_cnt <= wdt_cnt + WDT_W'(1);
            end

            // Fires in the stalled cycle whose edge brings the count to TIMEOUT.
            assign wdt_hit = !ex_ready && (wdt_cnt == WDT_PRE);
        end else begin : g_no_wdt
            assign wdt_hit = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pip_ctrl_mc.sv
// Directed bench for pip_ctrl_mc: reset, bypass/stall, scoreboard, flush FSM,
// watchdog and reset during FLUSH.
module tb_pip_ctrl_mc;

    localparam int NBACK = 2;
    localparam int IDX_W = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   id_valid;
    logic [IDX_W-1:0]       id_rs1_index;
    logic [IDX_W-1:0]       id_rs2_index;
    logic [IDX_W-1:0]       id_rd_index;
    logic                   id_gpr_write;
    logic                   id_long_op;
    logic                   id_exception;
    logic                   id_fence;
    logic [NBACK-1:0]       bk_valid;
    logic [NBACK*IDX_W-1:0] bk_rd_index;
    logic [NBACK-1:0]       bk_gpr_write;
    logic [NBACK-1:0]       bk_fwd_ok;
    logic [NBACK-1:0]       bk_exception;
    logic [NBACK-1:0]       bk_fence;
    logic                   ex_ready;
    logic                   lo_done;
    logic [IDX_W-1:0]       lo_done_index;
    logic                   redirect;
    logic                   if_nop;
    logic                   if_hold;
    logic                   id_nop;
    logic                   id_hold;
    logic [NBACK-1:0]       bk_nop;
    logic [NBACK-1:0]       fwd_rs1_sel;
    logic [NBACK-1:0]       fwd_rs2_sel;
    logic                   flushing;
    logic                   wdt_timeout;

    // {if_nop, if_hold, id_nop, id_hold, flushing, wdt_timeout}
    logic [31:0] ctl;
    assign ctl = {26'd0, if_nop, if_hold, id_nop, id_hold, flushing, wdt_timeout};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pip_ctrl_mc #(
        .NBACK  (NBACK),
        .IDX_W  (IDX_W),
        .FWD_EN (1),
        .TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1_index (id_rs1_index),
        .id_rs2_index (id_rs2_index),
        .id_rd_index  (id_rd_index),
        .id_gpr_write (id_gpr_write),
        .id_long_op   (id_long_op),
        .id_exception (id_exception),
        .id_fence     (id_fence),
        .bk_valid     (bk_valid),
        .bk_rd_index  (bk_rd_index),
        .bk_gpr_write (bk_gpr_write),
        .bk_fwd_ok    (bk_fwd_ok),
        .bk_exception (bk_exception),
        .bk_fence     (bk_fence),
        .ex_ready     (ex_ready),
        .lo_done      (lo_done),
        .lo_done_index(lo_done_index),
        .redirect     (redirect),
        .if_nop       (if_nop),
        .if_hold      (if_hold),
        .id_nop       (id_nop),
        .id_hold      (id_hold),
        .bk_nop       (bk_nop),
        .fwd_rs1_sel  (fwd_rs1_sel),
        .fwd_rs2_sel  (fwd_rs2_sel),
        .flushing     (flushing),
        .wdt_timeout  (wdt_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_valid      = 1'b0;
        id_rs1_index  = '0;
        id_rs2_index  = '0;
        id_rd_index   = '0;
        id_gpr_write  = 1'b0;
        id_long_op    = 1'b0;
        id_exception  = 1'b0;
        id_fence      = 1'b0;
        bk_valid      = '0;
        bk_rd_index   = '0;
        bk_gpr_write  = '0;
        bk_fwd_ok     = '0;
        bk_exception  = '0;
        bk_fence      = '0;
        ex_ready      = 1'b1;
        lo_done       = 1'b0;
        lo_done_index = '0;
        redirect      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();

        // reset and idle
        @(negedge clk); #1;
        chk("rst_ctl0", ctl, 'b101000);
        chk("rst_bknop", 32'(bk_nop), 'b11);
        chk("rst_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 0);
        @(negedge clk); #1;
        chk("rst_ctl1", ctl, 'b101000);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("idle_ctl", ctl, 0);
        chk("idle_bknop", 32'(bk_nop), 0);
        chk("idle_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 0);

        // bypass vs stall
        @(negedge clk);
        id_valid = 1'b1; id_rs1_index = 5'd5;
        bk_valid = 2'b01; bk_rd_index = {5'd0, 5'd5}; bk_gpr_write = 2'b01; bk_fwd_ok = 2'b01;
        #1;
        chk("byp_rs1_sel", 32'(fwd_rs1_sel), 'b01);
        chk("byp_ctl", ctl, 0);
        @(negedge clk); bk_fwd_ok = 2'b00; #1;
        chk("nofwd_sel", 32'(fwd_rs1_sel), 0);
        chk("nofwd_ctl", ctl, 'b011000);
        @(negedge clk);
        bk_valid = 2'b11; bk_rd_index = {5'd5, 5'd5}; bk_gpr_write = 2'b11; bk_fwd_ok = 2'b10;
        #1;
        chk("young_sel", 32'(fwd_rs1_sel), 0);
        chk("young_ctl", ctl, 'b011000);
        @(negedge clk); clr();
        id_valid = 1'b1; id_rs1_index = 5'd0; id_rs2_index = 5'd9;
        bk_valid = 2'b11; bk_rd_index = {5'd9, 5'd0}; bk_gpr_write = 2'b11; bk_fwd_ok = 2'b10;
        #1;
        chk("byp_rs2_sel", 32'(fwd_rs2_sel), 'b10);
        chk("x0_rs1_sel", 32'(fwd_rs1_sel), 0);
        chk("byp_rs2_ctl", ctl, 0);

        // scoreboard
        @(negedge clk); clr();
        id_valid = 1'b1; id_rd_index = 5'd7; id_gpr_write = 1'b1; id_long_op = 1'b1;
        #1;
        chk("lo_issue", ctl, 0);
        @(negedge clk); clr(); id_valid = 1'b1; id_rs1_index = 5'd7; #1;
        chk("sb_stall0", ctl, 'b011000);
        @(negedge clk); #1;
        chk("sb_stall1", ctl, 'b011000);
        @(negedge clk); lo_done = 1'b1; lo_done_index = 5'd7; #1;
        chk("sb_stall_done", ctl, 'b011000);
        @(negedge clk); lo_done = 1'b0; #1;
        chk("sb_resume", ctl, 0);
        @(negedge clk); clr();
        id_valid = 1'b1; id_rd_index = 5'd7; id_gpr_write = 1'b1; id_long_op = 1'b1;
        lo_done = 1'b1; lo_done_index = 5'd7;
        #1;
        chk("setclr_issue", ctl, 0);
        @(negedge clk); clr(); id_valid = 1'b1; id_rd_index = 5'd7; id_gpr_write = 1'b1; #1;
        chk("waw_stall", ctl, 'b011000);
        @(negedge clk); lo_done = 1'b1; lo_done_index = 5'd7; #1;
        chk("waw_stall_done", ctl, 'b011000);
        @(negedge clk); lo_done = 1'b0; #1;
        chk("waw_free", ctl, 0);

        // flush FSM
        @(negedge clk); clr(); bk_valid = 2'b10; bk_exception = 2'b10; #1;
        chk("flush_bknop", 32'(bk_nop), 'b01);
        chk("flush_ctl0", ctl, 'b101000);
        @(negedge clk); clr(); #1;
        chk("flushing1", ctl, 'b101010);
        chk("flushing_bknop", 32'(bk_nop), 0);
        @(negedge clk); redirect = 1'b1; #1;
        chk("flush_redir", ctl, 'b101010);
        @(negedge clk); redirect = 1'b0; #1;
        chk("flush_exit", ctl, 0);
        @(negedge clk); bk_valid = 2'b10; bk_fence = 2'b10; redirect = 1'b1; #1;
        chk("fence_redir", ctl, 'b101000);
        @(negedge clk); clr(); #1;
        chk("no_flush", ctl, 0);
        @(negedge clk); id_valid = 1'b1; id_exception = 1'b1; redirect = 1'b1; #1;
        chk("iexc_ctl", ctl, 'b100000);
        @(negedge clk); clr(); id_valid = 1'b1; id_fence = 1'b1; #1;
        chk("id_fence_hold", ctl, 'b010000);

        // watchdog
        @(negedge clk); clr(); #1;
        chk("wdt_pre", ctl, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); ex_ready = 1'b0; #1;
            chk($sformatf("wdt_a%0d", i), 32'(wdt_timeout), 32'(i == 3));
        end
        chk("wdt_stall_ctl", ctl, 'b010100);
        @(negedge clk); ex_ready = 1'b1; #1;
        chk("wdt_rearm_ctl", ctl, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); ex_ready = 1'b0; #1;
            chk($sformatf("wdt_b%0d", i), 32'(wdt_timeout), 32'(i == 3));
        end
        @(negedge clk); ex_ready = 1'b1; #1;

        // reset in FLUSH with a scoreboard bit set
        @(negedge clk); clr();
        id_valid = 1'b1; id_rd_index = 5'd9; id_gpr_write = 1'b1; id_long_op = 1'b1;
        #1;
        chk("r6_issue", ctl, 0);
        @(negedge clk); clr(); bk_valid = 2'b01; bk_exception = 2'b01; #1;
        chk("r6_flush_ctl", ctl, 'b101000);
        chk("r6_bknop", 32'(bk_nop), 0);
        @(negedge clk); clr(); #1;
        chk("r6_flushing", ctl, 'b101010);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("r6_rst_ctl", ctl, 'b101000);
        chk("r6_rst_bknop", 32'(bk_nop), 'b11);
        @(negedge clk); rst_n = 1'b1; id_valid = 1'b1; id_rs1_index = 5'd9; #1;
        chk("r6_after", ctl, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
